l2_replacement_unit: RTL

//   Parametrised victim-selection engine for the N-way set-associative L2 cache.

---
 rtl/l2_replacement_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/l2_replacement_unit.sv
// Victim-way selector for the N-way L2: RANDOM (LFSR), tree-PLRU and true-LRU
// policies with per-set state, preferring invalid ways and answering one cycle later.
module l2_replacement_unit #(
  parameter int          WAYS      = 4,
  parameter int          WAY_BITS  = 2,
  parameter int          SETS      = 256,
  parameter int          SET_BITS  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          replacement,
  input  logic                debug,
  input  logic                touch_en,
  input  logic [SET_BITS-1:0] touch_set,
  input  logic [WAY_BITS-1:0] touch_way,
  input  logic                victim_req,
  input  logic [SET_BITS-1:0] victim_set,
  input  logic [WAYS-1:0]     valid_mask,
  output logic                victim_vld,
  output logic [WAY_BITS-1:0] victim_way
);

  logic [15:0]         r_lfsr;
  logic [WAYS-2:0]     r_plru [SETS];
  logic [WAY_BITS-1:0] r_age  [SETS][WAYS];
  logic                r_victim_vld;
  logic [WAY_BITS-1:0] r_victim_way;

  logic                w_lfsr_fb;
  logic                w_has_invalid;
  logic [WAY_BITS-1:0] w_inv_way;
  logic [WAY_BITS-1:0] w_plru_way;
  logic [WAY_BITS-1:0] w_lru_way;
  logic [WAY_BITS-1:0] w_victim_way;
  logic [WAYS-2:0]     w_victim_plru;
  logic [WAYS-2:0]     w_touch_plru;
  logic [WAY_BITS-1:0] w_touched_age;
  logic [WAY_BITS-1:0] w_touch_age [WAYS];
  logic                w_unused_debug;

  // The trace request has no hardware meaning; it is only a simulation hook.
  assign w_unused_debug = debug;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Victim selection from the state held during the request cycle.
  // PLRU nodes are heap-ordered: node n has children 2n and 2n+1, stored at n-1.
  always_comb begin
    int node;
    w_victim_plru = r_plru[victim_set];
    node = 1;
    for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
      node = 2 * node + int'(w_victim_plru[node-1]);
    end
    w_plru_way = WAY_BITS'(node - WAYS);

    w_lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_age[victim_set][w] == WAY_BITS'(WAYS - 1)) begin
        w_lru_way = WAY_BITS'(w);
      end
    end

    w_has_invalid = ~&valid_mask;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mask[w]) begin
        w_inv_way = WAY_BITS'(w);
      end
    end

    if (w_has_invalid) begin
      w_victim_way = w_inv_way;
    end else begin
      case (replacement)
        2'd1:    w_victim_way = w_plru_way;
        2'd2:    w_victim_way = w_lru_way;
        default: w_victim_way = r_lfsr[WAY_BITS-1:0];
      endcase
    end
  end

  // Next per-set state for a touch; both policies track every access so a
  // runtime mode switch needs no warm-up.
  always_comb begin
    int node;
    w_touch_plru = r_plru[touch_set];
    node = 1;
    for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
      w_touch_plru[node-1] = ~touch_way[WAY_BITS-1-lvl];
      node = 2 * node + int'(touch_way[WAY_BITS-1-lvl]);
    end

    w_touched_age = r_age[touch_set][touch_way];
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_BITS'(w) == touch_way) begin
        w_touch_age[w] = '0;
      end else if (r_age[touch_set][w] < w_touched_age) begin
        w_touch_age[w] = r_age[touch_set][w] + 1'b1;
      end else begin
        w_touch_age[w] = r_age[touch_set][w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr       <= LFSR_SEED;
      r_victim_vld <= 1'b0;
      r_victim_way <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_age[s][w] <= WAY_BITS'(w);
        end
      end
    end else begin
      r_lfsr       <= {r_lfsr[14:0], w_lfsr_fb};
      r_victim_vld <= victim_req;
      if (victim_req) begin
        r_victim_way <= w_victim_way;
      end
      if (touch_en) begin
        r_plru[touch_set] <= w_touch_plru;
        for (int w = 0; w < WAYS; w++) begin
          r_age[touch_set][w] <= w_touch_age[w];
        end
      end
    end
  end

  assign victim_vld = r_victim_vld;
  assign victim_way = r_victim_way;

endmodule
